// File: rtl/mc_mem_responder_pkg.sv
// Shared definitions for the multicycle MIPS unified memory responder:
// word width, responder FSM encoding and word-index width helper.
package mips_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Number of word-index bits needed to address a power-of-2 array depth.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEFAULT_DEPTH = 256;
  localparam int DEFAULT_IDX_W = idx_w(DEFAULT_DEPTH);

endpackage

// File: rtl/mc_mem_responder_if.sv
// Request/response channel between the multicycle controller's address mux
// and the memory responder.
interface mc_mem_responder_if;
  import mips_mem_pkg::*;

  logic              req_valid;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mc_mem_responder_array.sv
// Single-port 32-bit RAM: write on the clock edge, read data follows the
// address combinationally so the responder can register it on RESP entry.
module mc_mem_array
  import mips_mem_pkg::*;
#(
  parameter  int DEPTH_WORDS = DEFAULT_DEPTH,
  localparam int IDX_W       = idx_w(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // NOTE: storage has no reset so it maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mc_mem_responder.sv
// Unified instruction/data memory responder for the multicycle MIPS
// controller: valid/ready request, fixed-latency one-cycle response pulse.
// Optional misaligned-access detection is enabled by MEM_ALIGN_CHECK_EN.
module mc_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH,
  parameter int LATENCY     = 2
) (
  input  logic                clk,
  input  logic                rst,
  mc_mem_responder_if.slave   bus
);

  localparam int         IDX_W    = idx_w(DEPTH_WORDS);
  localparam int         AW       = IDX_W + 2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state, next_state;
  logic [3:0]        cnt;
  logic              cap_we;
  logic [AW-1:0]     cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic [WORD_W-1:0] rdata_q;

  logic              accept;
  logic              enter_resp;
  logic              src_we;
  logic [AW-1:0]     src_addr;
  logic              src_err;
  logic              cap_err;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          next_state = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT:    if (cnt == 4'd1) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // In IDLE the live request drives the array so a LATENCY=1 read can be
  // registered on its acceptance edge; afterwards the captured request does.
  assign src_we     = (state == IDLE) ? bus.req_we : cap_we;
  assign src_addr   = (state == IDLE) ? bus.req_addr[AW-1:0] : cap_addr;
  assign enter_resp = (next_state == RESP) && (state != RESP);

`ifdef MEM_ALIGN_CHECK_EN
  assign src_err = |src_addr[1:0];
  assign cap_err = |cap_addr[1:0];
`else
  assign src_err = 1'b0;
  assign cap_err = 1'b0;
`endif

  // The store commits on the edge that ends RESP; a reset on that edge drops it.
  assign mem_we = (state == RESP) && cap_we && !cap_err && !rst;

  mc_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (src_addr[AW-1:2]),
    .wdata (cap_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        cap_we    <= bus.req_we;
        cap_addr  <= bus.req_addr[AW-1:0];
        cap_wdata <= bus.req_wdata;
        cnt       <= CNT_LOAD;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp && (!src_we || src_err)) begin
        rdata_q <= src_err ? '0 : mem_rdata;
      end
    end
  end

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = (state == RESP) && !rst;
  assign bus.rsp_err   = bus.rsp_valid && cap_err;
  assign bus.rsp_rdata = rdata_q;

  // Upper address bits alias by design; byte-offset bits matter only with the check.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.req_addr[WORD_W-1:AW], src_addr[1:0], cap_addr[1:0]};

endmodule

// File: tb/tb_mc_mem_responder.sv
// Scoreboard bench for mc_mem_responder: directed requests push expected
// responses; a negedge monitor pops and compares each rsp_valid pulse.
module tb_mc_mem_responder;
  import mips_mem_pkg::*;

  localparam int L = 2;
  localparam int D = 256;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mc_mem_responder_if bus ();

  mc_mem_responder #(
    .DEPTH_WORDS (D),
    .LATENCY     (L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at the negedge before the accepting edge; response lands L-1
  // negedges after the one following acceptance.
  task automatic push_exp(input logic we, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    e.err   = exp_err;
    e.rdata = exp_err ? 32'h0 : (we ? last_rd : exp_rd);
    e.cyc   = cyc + L;
    sb.push_back(e);
    last_rd = e.rdata;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input bit push,
                       output int acc_cyc);
    int budget = 50;
    bit done = 0;
    acc_cyc = -1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (!done && budget > 0) begin
      if (bus.req_ready === 1'b1) begin
        done = 1;
        acc_cyc = cyc;
        if (push) push_exp(we, exp_rd, exp_err);
      end
      @(negedge clk);
      budget--;
    end
    bus.req_valid = 1'b0;
    bus.req_wdata = 32'hBAD0_BAD0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: addr 0x%08h never accepted", addr);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
      end
    end
  end

  initial begin
    int t1, t2, tmp;
    int acc[$];
    logic [31:0] cur_addr;

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_ready", {31'h0, bus.req_ready}, 32'h0);
      check("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      check("reset_rdata", bus.rsp_rdata, 32'h0);
    end
    rst = 1'b0;
    #1;
    check("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);
    @(negedge clk);

    // Write then read back, accepted back to back
    issue(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, t1);
    issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1, t2);
    check("wr_rd_spacing", 32'(t2 - t1), 32'(L + 1));

    // Backpressure: valid held high, address switched while busy
    issue(1'b1, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0, 1, tmp);
    issue(1'b1, 32'h24, 32'h5A5A5A5A, 32'h0, 1'b0, 1, tmp);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h20;
    for (int i = 0; i < 12; i++) begin
      if (bus.req_ready === 1'b1) begin
        cur_addr = bus.req_addr;
        push_exp(1'b0, (cur_addr == 32'h20) ? 32'hA5A5A5A5 : 32'h5A5A5A5A, 1'b0);
        acc.push_back(cyc);
      end else if (acc.size() >= 2) begin
        bus.req_addr = 32'h24;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("bp_accept_count", 32'(acc.size()), 32'd4);
    for (int k = 1; k < acc.size(); k++) begin
      check("bp_accept_spacing", 32'(acc[k] - acc[k-1]), 32'(L + 1));
    end

    // Upper address bits alias: 0x400 wraps to word 0
    issue(1'b1, 32'h400, 32'h11111111, 32'h0, 1'b0, 1, tmp);
    issue(1'b0, 32'h000, 32'h0, 32'h11111111, 1'b0, 1, tmp);

    // Reset during WAIT abandons the pending store
    issue(1'b1, 32'h30, 32'h00000000, 32'h0, 1'b0, 1, tmp);
    issue(1'b0, 32'h30, 32'h0, 32'h00000000, 1'b0, 1, tmp);
    issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1, tmp);
    repeat (L + 1) @(negedge clk);
    issue(1'b1, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 0, tmp);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'h0;
    check("midreset_rdata_cleared", bus.rsp_rdata, 32'h0);
    repeat (L + 2) @(negedge clk);
    issue(1'b0, 32'h30, 32'h0, 32'h00000000, 1'b0, 1, tmp);

    // Misaligned store to 0x13
`ifdef MEM_ALIGN_CHECK_EN
    issue(1'b1, 32'h13, 32'h00000055, 32'h0, 1'b1, 1, tmp);
    issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1, tmp);
`else
    issue(1'b1, 32'h13, 32'h00000055, 32'h0, 1'b0, 1, tmp);
    issue(1'b0, 32'h10, 32'h0, 32'h00000055, 1'b0, 1, tmp);
`endif

    // Drain outstanding responses
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses still outstanding", sb.size());
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
